// File: rtl/mem_resp_stage.sv
// MEM stage: registers EXE bus, merges the data-SRAM read response (0 added cycles, 1-entry hold buffer), discards responses orphaned by flush.
// Stalls upstream via ms_allowin while a load waits or WB is blocked; `MEM_RESP_STALL_CNT_EN adds ms_stall_cnt.
module mem_resp_stage #(
  parameter int DATA_W    = 32,
  parameter int BUS_IN_W  = 174,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  input  logic [BUS_IN_W-1:0] es_to_ms_bus,
  output logic                ms_allowin,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [BUS_IN_W-46:0] ms_to_ws_bus,
  input  logic                data_sram_data_ok,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  input  logic                es_req_inflight,
  input  logic                wb_ex,
  input  logic                wb_ertn,
  output logic                out_ms_valid,
  output logic                ms_wait_resp
`ifdef MEM_RESP_STALL_CNT_EN
  ,
  output logic [31:0]         ms_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                ms_valid;
  logic                buf_valid;
  logic [BUS_IN_W-1:0] ms_bus;
  logic [DATA_W-1:0]   buf_data;
  logic [CNT_W-1:0]    discard_cnt;

  logic [31:0] pc, alu_result, mem_result, final_result;
  logic [4:0]  dest, ld_op;
  logic        gr_we, res_from_mem, mem_req;
  assign pc           = ms_bus[31:0];
  assign alu_result   = ms_bus[63:32];
  assign dest         = ms_bus[68:64];
  assign gr_we        = ms_bus[69];
  assign res_from_mem = ms_bus[70];
  assign mem_req      = ms_bus[71];
  assign ld_op        = ms_bus[76:72];

  logic flush, cnt_zero, resp_live, ms_waiting, ms_ready_go, ms_leave, buf_load;
  assign flush       = wb_ex || wb_ertn;
  assign cnt_zero    = (discard_cnt == '0);
  assign resp_live   = data_sram_data_ok && cnt_zero;
  assign ms_waiting  = ms_valid && mem_req && !buf_valid;
  assign ms_ready_go = !mem_req || buf_valid || resp_live;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_leave    = ms_to_ws_valid && ws_allowin;
  assign ms_wait_resp = ms_valid && mem_req && !ms_ready_go;
  assign out_ms_valid = ms_valid;

  // Early responses are only kept when EXE owns an unanswered request, so a
  // stale response after reset (nothing in flight) is simply dropped.
  assign buf_load = resp_live && !flush &&
                    ((ms_waiting && !ws_allowin) ||
                     (!ms_waiting && es_req_inflight &&
                      (!buf_valid || (ms_leave && mem_req))));

  logic [CNT_W+1:0] disc_sum;
  logic [CNT_W-1:0] discard_nxt;
  always_comb begin
    disc_sum = {2'b00, discard_cnt} - (CNT_W+2)'(data_sram_data_ok && !cnt_zero);
    if (flush)
      disc_sum = disc_sum + (CNT_W+2)'(ms_waiting && !data_sram_data_ok)
                          + (CNT_W+2)'(es_req_inflight);
    discard_nxt = (disc_sum > (CNT_W+2)'(MAX_OUTST)) ? CNT_W'(MAX_OUTST)
                                                      : disc_sum[CNT_W-1:0];
  end

  logic [DATA_W-1:0] mem_src, ld_shift;
  logic [OFF_W-1:0]  off;
  logic              mis_h, mis_w;
  assign mem_src  = buf_valid ? buf_data : data_sram_rdata;
  assign off      = alu_result[OFF_W-1:0];
  assign ld_shift = mem_src >> {off, 3'b000};
  assign mis_h    = alu_result[0];
  assign mis_w    = |alu_result[1:0];

  always_comb begin
    mem_result = '0;
    if (ld_op[4])                mem_result = {{24{ld_shift[7]}}, ld_shift[7:0]};
    else if (ld_op[3])           mem_result = {24'd0, ld_shift[7:0]};
    else if (ld_op[2] && !mis_h) mem_result = {{16{ld_shift[15]}}, ld_shift[15:0]};
    else if (ld_op[1] && !mis_h) mem_result = {16'd0, ld_shift[15:0]};
    else if (ld_op[0] && !mis_w) mem_result = ld_shift[31:0];
  end
  assign final_result = res_from_mem ? mem_result : alu_result;

  // Output keeps the low BUS_IN_W-45 bits; passthrough is the lowest bus bits above 76.
  logic [BUS_IN_W-1:0]  pt_all;
  logic [BUS_IN_W+69:0] out_full;
  assign pt_all       = ms_bus >> 77;
  assign out_full     = {pt_all, gr_we, dest, final_result, pc};
  assign ms_to_ws_bus = ms_valid ? out_full[BUS_IN_W-46:0] : '0;

  logic unused_ok;
  assign unused_ok = ^{ld_shift, out_full[BUS_IN_W+69:BUS_IN_W-45]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= '0;
    end else begin
      if (flush)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (flush)                    buf_valid <= 1'b0;
      else if (buf_load)            buf_valid <= 1'b1;
      else if (ms_leave && mem_req) buf_valid <= 1'b0;
      discard_cnt <= discard_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin && !flush) ms_bus <= es_to_ms_bus;
    if (buf_load) buf_data <= data_sram_rdata;
  end

`ifdef MEM_RESP_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             ms_stall_cnt <= '0;
    else if (ms_wait_resp) ms_stall_cnt <= ms_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: DATA_W=32 and DATA_W=64 instances share stimulus.
module tb_mem_resp_stage;
  localparam int BW = 174;
  localparam int OW = BW - 45;
  localparam logic [4:0] LDB = 5'b10000, LDBU = 5'b01000, LDH = 5'b00100,
                         LDHU = 5'b00010, LDW = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, es_v, ws_a, dok, infl, wb_ex, wb_ertn;
  logic [BW-1:0] es_bus;
  logic [63:0]   rd64;
  logic allow32, wsv32, ovld32, wait32, allow64, wsv64, ovld64, wait64;
  logic [OW-1:0] bus32, bus64;
`ifdef MEM_RESP_STALL_CNT_EN
  logic [31:0] stall32, stall64;
`endif

  mem_resp_stage #(.DATA_W(32), .BUS_IN_W(BW), .MAX_OUTST(2)) u32 (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_v), .es_to_ms_bus(es_bus),
    .ms_allowin(allow32), .ws_allowin(ws_a), .ms_to_ws_valid(wsv32), .ms_to_ws_bus(bus32),
    .data_sram_data_ok(dok), .data_sram_rdata(rd64[31:0]), .es_req_inflight(infl),
    .wb_ex(wb_ex), .wb_ertn(wb_ertn), .out_ms_valid(ovld32), .ms_wait_resp(wait32)
`ifdef MEM_RESP_STALL_CNT_EN
    , .ms_stall_cnt(stall32)
`endif
  );

  mem_resp_stage #(.DATA_W(64), .BUS_IN_W(BW), .MAX_OUTST(2)) u64 (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_v), .es_to_ms_bus(es_bus),
    .ms_allowin(allow64), .ws_allowin(ws_a), .ms_to_ws_valid(wsv64), .ms_to_ws_bus(bus64),
    .data_sram_data_ok(dok), .data_sram_rdata(rd64), .es_req_inflight(infl),
    .wb_ex(wb_ex), .wb_ertn(wb_ertn), .out_ms_valid(ovld64), .ms_wait_resp(wait64)
`ifdef MEM_RESP_STALL_CNT_EN
    , .ms_stall_cnt(stall64)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
      input logic [4:0] dest, input logic gw, input logic rfm, input logic mreq,
      input logic [4:0] ld, input logic [58:0] pt);
    return {38'h2A_AAAA_AAAA, pt, ld, mreq, rfm, gw, dest, alu, pc};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [BW-1:0] b, input logic wa, input logic ok,
      input logic [63:0] rd, input logic inf, input logic ex, input logic er);
    es_v = v; es_bus = b; ws_a = wa; dok = ok; rd64 = rd; infl = inf; wb_ex = ex; wb_ertn = er;
  endtask

  typedef struct {
    logic        es_v;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        rfm;
    logic        mreq;
    logic [4:0]  ld;
    logic        ws_a;
    logic        dok;
    logic [31:0] rd;
    logic        e_allow;
    logic        e_ovld;
    logic        e_wsv;
    logic        e_wait;
    logic [31:0] e_res;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] exp_bus;
    logic [58:0]   pt;
    tbl[0]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 32'h104, 32'h1003,     1'b1, 1'b1, LDB,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678};
    tbl[3]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b1, 32'h80FF1234, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b1, 32'h108, 32'h2002,     1'b1, 1'b1, LDHU, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 32'hBEEF1234, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BEEF};
    tbl[6]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BEEF};
    tbl[7]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BEEF};
    tbl[8]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0000BEEF};
    tbl[9]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h10C, 32'h3001,     1'b1, 1'b1, LDW,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 32'h110, 32'h4002,     1'b1, 1'b1, LDH,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b1, 32'h80010000, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF8001};
    tbl[15] = '{1'b1, 32'h114, 32'h5001,     1'b1, 1'b1, LDBU, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 5'b0, 1'b1, 1'b1, 32'h0000F000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000F0};

    drv(1'b0, '0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allowin", allow32, 1'b1);
    chk("rst_out_valid", ovld32, 1'b0);
    chk("rst_to_ws_valid", wsv32, 1'b0);
    chk("rst_wait", wait32, 1'b0);
    chk("rst_bus", bus32, '0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drv(tbl[i].es_v, mk_bus(tbl[i].pc, tbl[i].alu, 5'd3, 1'b1, tbl[i].rfm, tbl[i].mreq,
          tbl[i].ld, 59'h0), tbl[i].ws_a, tbl[i].dok, {32'h0, tbl[i].rd}, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_allowin", i), allow32, tbl[i].e_allow);
      chk($sformatf("v%0d_out_valid", i), ovld32, tbl[i].e_ovld);
      chk($sformatf("v%0d_to_ws_valid", i), wsv32, tbl[i].e_wsv);
      chk($sformatf("v%0d_wait", i), wait32, tbl[i].e_wait);
      if (tbl[i].e_wsv) chk($sformatf("v%0d_result", i), bus32[63:32], tbl[i].e_res);
    end

    // Flush with a waiting load plus an EXE request in flight: two responses to drop.
    next_cycle(); drv(1'b1, mk_bus(32'h200, 32'h6000, 5'd4, 1'b1, 1'b1, 1'b1, LDW, 59'h0), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("s1_wait_before_flush", wait32, 1'b1);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    next_cycle(); drv(1'b1, mk_bus(32'h300, 32'h7000, 5'd5, 1'b1, 1'b1, 1'b1, LDW, 59'h0), 1'b1, 1'b1, 64'h11111111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s1_discard_cnt", u32.discard_cnt, 2'd2);
    chk("s1_flushed_valid", ovld32, 1'b0);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b1, 64'h22222222, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s1_drop2_valid", wsv32, 1'b0);
    chk("s1_drop2_wait", wait32, 1'b1);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b1, 64'h33333333, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s1_third_valid", wsv32, 1'b1);
    chk("s1_third_result", bus32[63:32], 32'h33333333);
    // Flush (ertn) wins over accepting a new instruction.
    next_cycle(); drv(1'b1, mk_bus(32'h304, 32'h55, 5'd6, 1'b1, 1'b0, 1'b0, 5'b0, 59'h0), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("s1_ertn_allowin", allow32, 1'b1);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s1_ertn_not_accepted", ovld32, 1'b0);
    chk("s1_discard_zero", u32.discard_cnt, 2'd0);

    // 64-bit lane pick plus full output bus layout.
    pt = 59'h123_4567_89AB_CDEF;
    next_cycle(); drv(1'b1, mk_bus(32'h400, 32'h8006, 5'h1A, 1'b1, 1'b1, 1'b1, LDHU, pt), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b1, 64'hBEEF_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s2_w64_valid", wsv64, 1'b1);
    chk("s2_w64_result", bus64[63:32], 32'h0000BEEF);
    exp_bus = {pt, 1'b1, 5'h1A, 32'h0, 32'h400};
    chk("s2_w32_bus", bus32, exp_bus);

    // Reset in the middle of a stall, then a stale response must be dropped.
    next_cycle(); drv(1'b1, mk_bus(32'h500, 32'h9000, 5'd7, 1'b1, 1'b1, 1'b1, LDW, 59'h0), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("s3_stalled", wait32, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("s3_async_allowin", allow32, 1'b1);
    chk("s3_async_out_valid", ovld32, 1'b0);
    chk("s3_async_wait", wait32, 1'b0);
    chk("s3_async_to_ws_valid", wsv32, 1'b0);
    chk("s3_async_bus", bus32, '0);
    next_cycle(); reset = 1'b0;
    drv(1'b1, mk_bus(32'h504, 32'hA000, 5'd8, 1'b1, 1'b1, 1'b1, LDW, 59'h0), 1'b1, 1'b1, 64'h5555AAAA, 1'b0, 1'b0, 1'b0);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s3_stale_dropped_valid", wsv32, 1'b0);
    chk("s3_stale_dropped_wait", wait32, 1'b1);
    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b1, 64'h600D600D, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s3_new_valid", wsv32, 1'b1);
    chk("s3_new_result", bus32[63:32], 32'h600D600D);

`ifdef MEM_RESP_STALL_CNT_EN
    begin : stall_seq
      logic [31:0] s0;
      next_cycle(); drv(1'b1, mk_bus(32'h600, 32'hB000, 5'd9, 1'b1, 1'b1, 1'b1, LDW, 59'h0), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); s0 = stall32;
      for (int k = 0; k < 5; k++) begin
        next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      end
      next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b1, 64'h7, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("s4_stall_delta", stall32 - s0, 32'd5);
      chk("s4_done_valid", wsv32, 1'b1);
    end
`endif

    next_cycle(); drv(1'b0, es_bus, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
